// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt,
    StFault
  } fetch_state_e;

  // Sentinel instruction that ends execution.
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection and fetch address legality check.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        fault_req
);

  logic [31:0] check_addr;

  // Redirect target replaces the sequential pc+4; the address being committed is range-checked.
  always_comb begin
    next_pc    = redirect ? redirect_pc : (pc + 32'd4);
    check_addr = redirect ? redirect_pc : pc;
    // A sequential pc is always aligned, so the alignment test only matters for redirects.
    fault_req  = (check_addr[1:0] != 2'b00) || ((check_addr >> 2) >= DEPTH);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, addresses instruction memory and registers the instruction.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         instr_valid_q;
  logic         halted_q;
  logic         fault_q;
  logic [31:0]  count_q;

  logic [31:0]  next_pc;
  logic         fault_req;

  fetch_pc_gen #(
    .DEPTH (DEPTH)
  ) u_pc_gen (
    .pc          (pc_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .next_pc     (next_pc),
    .fault_req   (fault_req)
  );

  // Word index presented to memory straight from the pc register.
  always_comb begin
    imem_addr = pc_q >> 2;
  end

  // Fetch FSM with all outputs registered; redirect > stall > run-off > halt > fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      count_q       <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (redirect) begin
            // Offending target is kept in pc on a fault so it stays observable.
            pc_q          <= next_pc;
            instr_valid_q <= 1'b0;
            if (fault_req) begin
              state_q  <= StFault;
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
            end
          end else if (stall) begin
            // Downstream not ready: everything holds.
          end else if (fault_req) begin
            state_q       <= StFault;
            halted_q      <= 1'b1;
            fault_q       <= 1'b1;
            instr_valid_q <= 1'b0;
          end else if (imem_instr == HALT_WORD) begin
            // Sentinel is neither delivered nor counted; pc stays on it.
            state_q       <= StHalt;
            halted_q      <= 1'b1;
            instr_valid_q <= 1'b0;
          end else begin
            instr_q       <= imem_instr;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= next_pc;
            if (count_q != 32'hFFFF_FFFF) begin
              count_q <= count_q + 32'd1;
            end
          end
        end
        StHalt, StFault: begin
          // Terminal until reset.
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign instr_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch controller for the single-cycle RISC-V core. Owns the PC, drives the word address into the 32-entry instruction memory and registers the returned instruction for decode.
- Handles start, stall, branch/jump redirect, the halt sentinel word (0xFFFFFFFF) and out-of-range fetch faults.
- Sits between instruction memory and the decode/execute stage.

Parameters:
- DEPTH, 32, instruction memory depth in words.
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, sentinel instruction that ends execution.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching; sampled only in IDLE.
- stall  in  1  hold fetch state; downstream not ready.
- redirect  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  32  byte target PC for redirect.
- imem_addr  out  32  word index to instruction memory, equal to pc >> 2; combinational from the pc register.
- imem_instr  in  32  instruction word read combinationally from memory.
- instr  out  32  registered instruction for decode.
- instr_pc  out  32  byte PC of instr.
- instr_valid  out  1  instr is a valid, non-flushed instruction.
- halted  out  1  HALT or FAULT state.
- fault  out  1  misaligned or out-of-range fetch.
- instr_count  out  32  instructions delivered, saturating.

Behaviour:
- Async reset (rst_n=0) forces these values immediately:
  - state=IDLE, pc=RESET_PC
  - instr=0x00000013 (NOP), instr_pc=0
  - instr_valid=0, halted=0, fault=0, instr_count=0
- Reset asserted mid-operation discards everything in flight.
- States are IDLE, RUN, HALT, FAULT.
- IDLE:
  - imem_addr=pc>>2 and instr_valid=0.
  - start=1 moves to RUN on the next edge.
- RUN, rules evaluated per edge in this priority order:
  1. redirect=1:
     - If redirect_pc[1:0]!=0 or redirect_pc>>2 >= DEPTH, go to FAULT.
     - Otherwise pc<=redirect_pc and instr_valid<=0 (flush the wrong-path fetch).
     - Redirect wins over stall and over a HALT_WORD fetched in the same cycle.
  2. stall=1: pc, instr, instr_pc, instr_valid and instr_count all hold.
  3. pc>>2 >= DEPTH (sequential run-off): go to FAULT, instr_valid<=0.
  4. imem_instr==HALT_WORD: go to HALT, instr_valid<=0, pc holds at the sentinel address. The sentinel is never delivered or counted.
  5. Otherwise, normal fetch:
     - instr<=imem_instr, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
     - instr_count<=instr_count+1, saturating at 0xFFFFFFFF.
- Latency: an instruction fetched at edge N is valid on outputs after edge N; sustained rate is one per cycle when stall=0.
- HALT: halted=1, instr_valid=0. start, stall and redirect are ignored; only reset exits.
- FAULT: halted=1, fault=1, instr_valid=0, pc holds the offending value. Only reset exits.
- Width rules: pc arithmetic is 32-bit modulo 2^32. Wrap-around is always caught by the range check before the address is used.

Decomposition:
- Package fetch_pkg holds:
  - state enum (IDLE, RUN, HALT, FAULT)
  - HALT_WORD and NOP_INSTR (0x00000013) constants
  - RESET_PC default
- One natural sub-module, fetch_pc_gen:
  - Next-PC mux (pc+4 vs redirect_pc).
  - Alignment/range check producing the fault_req signal.
- The FSM, output registers and counter stay in fetch_sequencer.

Test Plan:
- Program {0x00500093, 0x00308113, 0xFFFFFFFF}, start pulse:
  - instr_valid high two cycles, with instr_pc=0 then 4.
  - Third cycle halted=1 with imem_addr=2 held; instr_count=2.
- Stall=1 for 3 cycles after first delivery: instr, instr_pc=0 and instr_count=1 held throughout; fetch resumes at pc=4 after release.
- Redirect to 0x10 in the same cycle the memory returns 0xFFFFFFFF:
  - No halt; instr_valid=0 for one cycle.
  - Next delivered instr_pc=0x10.
- Redirect to 0x06 (misaligned), and separately 0x80 (word 32 ≥ DEPTH): fault=1, halted=1, pc=0x06 / 0x80, no further instr_valid.
- Program with no sentinel: after word 31 delivered (instr_pc=0x7C), next cycle fault=1 and instr_count=32.
- rst_n low while in RUN at pc=0x0C: all outputs drop to their reset values asynchronously. After release the block stays IDLE until start, then restarts at pc=0.
